// File: rtl/ecc_pkg.sv
// Shared types and encodings for the ECC decoder controller.
package ecc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } dec_ctrl_state_t;

  // CodeWord_Width codes
  localparam logic [1:0] CW_W8  = 2'b00;
  localparam logic [1:0] CW_W16 = 2'b01;
  localparam logic [1:0] CW_W32 = 2'b10;
  localparam logic [1:0] CW_ILL = 2'b11;

  // Result status codes
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_BADW = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  // Decoder num_of_error codes
  localparam logic [1:0] NERR_NONE   = 2'b00;
  localparam logic [1:0] NERR_CORR   = 2'b01;
  localparam logic [1:0] NERR_UNCORR = 2'b10;

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ecc_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] q
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/ecc_decode_ctrl.sv
// Sequences a single Decoder: issue a one-cycle enable, wait for ready with
// a timeout, capture the result and keep corrected/uncorrectable statistics.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | dec_en high for this single cycle, decoder ready ignored
// WAIT  | waiting for dec_ready, timer counts toward timeout
// DONE  | res_valid high for this single cycle
module ecc_decode_ctrl
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [1:0]            cmd_width,
  input  logic                  stat_clr,
  output logic                  dec_en,
  output logic [DATA_WIDTH-1:0] dec_data,
  output logic [AMBA_WORD-1:0]  dec_cw_width,
  input  logic [DATA_WIDTH-1:0] dec_data_out,
  input  logic [1:0]            dec_num_err,
  input  logic                  dec_ready,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [1:0]            res_num_err,
  output logic [1:0]            res_status,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cnt_corrected,
  output logic [CNT_WIDTH-1:0]  cnt_uncorr
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  dec_ctrl_state_t state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  dec_en_q, dec_en_d;
  logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d;
  logic [1:0]            dec_cw_q, dec_cw_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [1:0]            res_nerr_q, res_nerr_d;
  logic [1:0]            res_status_q, res_status_d;
  logic                  inc_corr, inc_uncorr;

  // State and registered outputs; dec_en clears asynchronously with reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      dec_en_q     <= 1'b0;
      dec_data_q   <= '0;
      dec_cw_q     <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_nerr_q   <= '0;
      res_status_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dec_en_q     <= dec_en_d;
      dec_data_q   <= dec_data_d;
      dec_cw_q     <= dec_cw_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_nerr_q   <= res_nerr_d;
      res_status_q <= res_status_d;
    end
  end

  // Next-state: illegal widths skip the decoder; ready beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_width == CW_ILL) ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (dec_ready || (timer_q == TMO_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values and statistics increments.
  always_comb begin
    timer_d      = timer_q;
    dec_en_d     = 1'b0;
    dec_data_d   = dec_data_q;
    dec_cw_d     = dec_cw_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_nerr_d   = res_nerr_q;
    res_status_d = res_status_q;
    inc_corr     = 1'b0;
    inc_uncorr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dec_data_d = cmd_data;
          dec_cw_d   = cmd_width;
          if (cmd_width == CW_ILL) begin
            res_valid_d  = 1'b1;
            res_data_d   = '0;
            res_nerr_d   = NERR_NONE;
            res_status_d = ST_BADW;
          end else begin
            dec_en_d = 1'b1;
          end
        end
      end
      ISSUE: timer_d = '0;
      WAIT: begin
        if (dec_ready) begin
          res_valid_d  = 1'b1;
          res_data_d   = dec_data_out;
          res_nerr_d   = dec_num_err;
          res_status_d = ST_OK;
          inc_corr     = (dec_num_err == NERR_CORR);
          inc_uncorr   = dec_num_err[1];
        end else if (timer_q == TMO_LAST) begin
          res_valid_d  = 1'b1;
          res_data_d   = '0;
          res_nerr_d   = NERR_NONE;
          res_status_d = ST_TMO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_corr (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_corr),
    .clr   (stat_clr),
    .q     (cnt_corrected)
  );

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_uncorr (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_uncorr),
    .clr   (stat_clr),
    .q     (cnt_uncorr)
  );

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign dec_en       = dec_en_q;
  assign dec_data     = dec_data_q;
  assign dec_cw_width = {{(AMBA_WORD-2){1'b0}}, dec_cw_q};
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_num_err  = res_nerr_q;
  assign res_status   = res_status_q;

endmodule

// File: tb/tb_ecc_decode_ctrl.sv
// Randomized bench for ecc_decode_ctrl with a transaction-level reference model.
`timescale 1ns/1ps
module tb_ecc_decode_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [1:0]    cmd_width;
  logic          stat_clr;
  logic          dec_en;
  logic [DW-1:0] dec_data;
  logic [AW-1:0] dec_cw_width;
  logic [DW-1:0] dec_data_out;
  logic [1:0]    dec_num_err;
  logic          dec_ready;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [1:0]    res_num_err;
  logic [1:0]    res_status;
  logic          busy;
  logic [CW-1:0] cnt_corrected;
  logic [CW-1:0] cnt_uncorr;

  ecc_decode_ctrl #(
    .AMBA_WORD   (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (TMO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .cmd_width     (cmd_width),
    .stat_clr      (stat_clr),
    .dec_en        (dec_en),
    .dec_data      (dec_data),
    .dec_cw_width  (dec_cw_width),
    .dec_data_out  (dec_data_out),
    .dec_num_err   (dec_num_err),
    .dec_ready     (dec_ready),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_num_err   (res_num_err),
    .res_status    (res_status),
    .busy          (busy),
    .cnt_corrected (cnt_corrected),
    .cnt_uncorr    (cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int            m_corr = 0;
  int            m_uncorr = 0;
  logic [DW-1:0] m_res_data = '0;
  logic [1:0]    m_res_nerr = '0;
  logic [1:0]    m_res_status = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One command; d = WAIT cycle index in which the decoder answers (>= TMO: never).
  task automatic run_cmd(input logic [DW-1:0] data, input logic [1:0] w, input int d,
                         input logic [DW-1:0] dout, input logic [1:0] nerr,
                         input bit hold, input bit stale, input bit clr_same);
    int lat = 0;
    int en_cnt = 0;
    int bad_busy = 0;
    int bad_hold = 0;
    int exp_lat;
    logic [DW-1:0] e_data;
    logic [1:0] e_nerr, e_st;

    if (w == 2'b11) begin
      exp_lat = 1;   e_st = 2'b01; e_data = '0;   e_nerr = 2'b00;
    end else if (d < TMO) begin
      exp_lat = 3 + d; e_st = 2'b00; e_data = dout; e_nerr = nerr;
    end else begin
      exp_lat = TMO + 2; e_st = 2'b10; e_data = '0; e_nerr = 2'b00;
    end

    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_width = w;
    dec_ready = 1'b0;
    @(negedge clk);
    for (int cyc = 1; cyc <= TMO + 8 && lat == 0; cyc++) begin
      if (!hold) cmd_valid = 1'b0;
      cmd_data  = $urandom;
      cmd_width = 2'($urandom);
      if (dec_en) en_cnt++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) bad_busy++;
      if (dec_data !== data || dec_cw_width !== {{(AW-2){1'b0}}, w}) bad_hold++;
      if (res_valid) begin
        lat = cyc;
      end else begin
        dec_ready    = (cyc == 1) ? stale : (w != 2'b11 && cyc == 2 + d);
        dec_data_out = (cyc != 1 && dec_ready) ? dout : DW'($urandom);
        dec_num_err  = (cyc != 1 && dec_ready) ? nerr : 2'($urandom);
        stat_clr     = clr_same && (cyc == 2 + d);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    dec_ready = 1'b0;
    stat_clr  = 1'b0;

    if (e_st == 2'b00 && clr_same) begin
      m_corr = 0;
      m_uncorr = 0;
    end else if (e_st == 2'b00 && nerr == 2'b01) begin
      m_corr = sat_inc(m_corr);
    end else if (e_st == 2'b00 && nerr[1]) begin
      m_uncorr = sat_inc(m_uncorr);
    end
    m_res_data = e_data;
    m_res_nerr = e_nerr;
    m_res_status = e_st;

    chk("latency", 64'(lat), 64'(exp_lat));
    chk("dec_en_pulses", 64'(en_cnt), (w == 2'b11) ? 64'd0 : 64'd1);
    chk("busy_while_active", 64'(bad_busy), 64'd0);
    chk("dec_inputs_held", 64'(bad_hold), 64'd0);
    chk("res_status", {62'd0, res_status}, {62'd0, e_st});
    chk("res_data", {32'd0, res_data}, {32'd0, e_data});
    chk("res_num_err", {62'd0, res_num_err}, {62'd0, e_nerr});

    @(negedge clk);
    chk("res_valid_one_cycle", {63'd0, res_valid}, 64'd0);
    chk("back_to_idle", {62'd0, cmd_ready, busy}, 64'd2);
    chk("res_data_hold", {32'd0, res_data}, {32'd0, m_res_data});
    chk("res_status_hold", {62'd0, res_status}, {62'd0, m_res_status});
    chk("cnt_corrected", {56'd0, cnt_corrected}, 64'(m_corr));
    chk("cnt_uncorr", {56'd0, cnt_uncorr}, 64'(m_uncorr));
  endtask

  task automatic do_clr();
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    m_corr = 0;
    m_uncorr = 0;
    chk("clr_corrected", {56'd0, cnt_corrected}, 64'd0);
    chk("clr_uncorr", {56'd0, cnt_uncorr}, 64'd0);
    chk("clr_fsm_idle", {62'd0, cmd_ready, busy}, 64'd2);
  endtask

  // Start a never-answered command and assert reset asynchronously in cycle 'at'.
  task automatic reset_mid(input int at);
    int rv = 0;
    chk("cmd_ready_pre_reset", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_data  = $urandom;
    cmd_width = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (at - 1) @(negedge clk);
    if (at == 1) chk("dec_en_in_issue", {63'd0, dec_en}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_dec_en", {63'd0, dec_en}, 64'd0);
    chk("rst_busy", {62'd0, busy, cmd_ready}, 64'd1);
    chk("rst_res", {28'd0, res_valid, res_data, res_num_err, res_status}, 64'd0);
    chk("rst_cnt", {48'd0, cnt_corrected, cnt_uncorr}, 64'd0);
    chk("rst_dec_data", {32'd0, dec_data}, 64'd0);
    m_corr = 0;
    m_uncorr = 0;
    m_res_data = '0;
    m_res_nerr = '0;
    m_res_status = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      if (res_valid) rv++;
      @(negedge clk);
    end
    chk("no_res_after_reset", 64'(rv), 64'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] base;
    base = 32'hAAAA_AAAA;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    cmd_width = '0;
    stat_clr = 1'b0;
    dec_data_out = '0;
    dec_num_err = '0;
    dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", {62'd0, cmd_ready, busy}, 64'd2);
    chk("reset_dec", {31'd0, dec_en, dec_data}, 64'd0);
    chk("reset_cw_width", {32'd0, dec_cw_width}, 64'd0);
    chk("reset_res", {28'd0, res_valid, res_data, res_num_err, res_status}, 64'd0);
    chk("reset_cnt", {48'd0, cnt_corrected, cnt_uncorr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Clean decode, ready on the first WAIT cycle
    run_cmd(base, 2'b10, 0, base, 2'b00, 0, 0, 0);
    // Single and double bit flips
    run_cmd(base ^ 32'h0000_0020, 2'b10, 1, base, 2'b01, 0, 0, 0);
    run_cmd(base ^ 32'h0000_0600, 2'b01, 2, base, 2'b10, 0, 1, 0);
    // Illegal width
    run_cmd(32'h1234_5678, 2'b11, 0, base, 2'b01, 0, 1, 0);
    // Timeout, then ready on the last WAIT cycle
    run_cmd(32'hDEAD_BEEF, 2'b00, TMO, 32'h5555_5555, 2'b01, 0, 0, 0);
    run_cmd(32'hCAFE_F00D, 2'b00, TMO - 1, 32'h0BAD_CAFE, 2'b01, 0, 0, 0);
    // Command held valid while busy
    run_cmd(32'h0F0F_0F0F, 2'b10, 4, 32'h0F0F_0F0E, 2'b11, 1, 0, 0);
    run_cmd(32'h7777_7777, 2'b11, 0, '0, 2'b00, 1, 0, 0);
    // Saturation of both counters
    for (int i = 0; i < CMAX + 3; i++)
      run_cmd($urandom, 2'b10, 0, $urandom, 2'b01, 0, 0, 0);
    for (int i = 0; i < CMAX + 3; i++)
      run_cmd($urandom, 2'b01, 0, $urandom, (i % 2 == 0) ? 2'b10 : 2'b11, 0, 0, 0);
    // Clear coinciding with an increment
    run_cmd($urandom, 2'b10, 3, $urandom, 2'b01, 0, 0, 1);
    run_cmd($urandom, 2'b10, 0, $urandom, 2'b10, 0, 0, 0);
    // Reset during WAIT and during ISSUE, then normal operation
    reset_mid(4);
    run_cmd(base, 2'b10, 2, 32'h1357_9BDF, 2'b01, 0, 0, 0);
    run_cmd($urandom, 2'b00, 0, $urandom, 2'b10, 0, 0, 0);
    reset_mid(1);
    run_cmd(base, 2'b01, 0, 32'h2468_ACE0, 2'b00, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      logic [1:0] w;
      w = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_cmd($urandom, w, $urandom_range(0, TMO + 3), $urandom, 2'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 15) == 0) do_clr();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
